// File: rtl/commutator_ctrl.sv
// Cross-switch sequencer for one streaming FFT stage: counts accepted samples and
// emits registered ce/straight/index. Optional drain phase under `COMMUTATOR_FLUSH_EN.
module commutator_ctrl #(
  parameter int LOG_N  = 6,
  parameter int SW_LOG = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             hold,
  output logic             ce,
  output logic             straight,
  output logic [LOG_N-1:0] sample_idx,
  output logic             busy,
  output logic             flushing,
  output logic             frame_done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [LOG_N-1:0] ZERO = '0;
  localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);
  localparam logic [LOG_N-1:0] LAST = '1;
`ifdef COMMUTATOR_FLUSH_EN
  localparam logic [LOG_N-1:0] FLAST = LOG_N'((1 << SW_LOG) - 1);
`endif

  state_t           state, state_n;
  logic [LOG_N-1:0] cnt, cnt_n;
  logic             acc;
  logic             issue, fd_n, err_n;
  logic [LOG_N-1:0] issue_idx;

  assign acc = in_valid & ~hold;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt is the index the next issued sample will carry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (acc && in_sof) begin
        state_n = RUN;
        cnt_n   = ONE;
      end
      RUN: if (acc) begin
        if (in_sof && cnt != ZERO) cnt_n = ONE;
        else if (cnt == LAST) begin
          cnt_n = '0;
`ifdef COMMUTATOR_FLUSH_EN
          state_n = FLUSH;
`else
          state_n = IDLE;
`endif
        end else cnt_n = cnt + ONE;
      end
`ifdef COMMUTATOR_FLUSH_EN
      FLUSH: if (!hold) begin
        if (acc && in_sof) begin
          state_n = RUN;
          cnt_n   = ONE;
        end else if (cnt == FLAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    issue_idx = cnt;
    fd_n      = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (acc) begin
        if (in_sof) begin
          issue     = 1'b1;
          issue_idx = '0;
        end else err_n = 1'b1;
      end
      RUN: if (acc) begin
        issue = 1'b1;
        if (in_sof && cnt != ZERO) begin
          err_n     = 1'b1;
          issue_idx = '0;
        end else begin
`ifndef COMMUTATOR_FLUSH_EN
          fd_n = (cnt == LAST);
`endif
        end
      end
`ifdef COMMUTATOR_FLUSH_EN
      // sof aborts the drain and closes out the old frame on the same ce
      FLUSH: if (!hold) begin
        issue = 1'b1;
        if (acc && in_sof) begin
          issue_idx = '0;
          fd_n      = 1'b1;
        end else begin
          err_n = acc;
          fd_n  = (cnt == FLAST);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ce         <= 1'b0;
      straight   <= 1'b1;
      sample_idx <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      ce         <= issue;
      frame_done <= fd_n;
      err        <= err_n;
      busy       <= (state_n != IDLE);
      if (issue) begin
        sample_idx <= issue_idx;
        straight   <= ~issue_idx[SW_LOG];
      end
    end
  end

`ifdef COMMUTATOR_FLUSH_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) flushing <= 1'b0;
    else      flushing <= (state_n == FLUSH);
  end
`else
  assign flushing = 1'b0;
`endif

endmodule

// File: tb/tb_commutator_ctrl.sv
// Scoreboard bench for commutator_ctrl at N=8, flush of 2; expectations follow
// whether COMMUTATOR_FLUSH_EN is defined for the build.
module tb_commutator_ctrl;

`ifdef COMMUTATOR_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0, in_sof = 1'b0, hold = 1'b0;
  logic       ce, straight, busy, flushing, frame_done, err;
  logic [2:0] sample_idx;

  commutator_ctrl #(.LOG_N(3), .SW_LOG(1)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sof(in_sof), .hold(hold),
    .ce(ce), .straight(straight), .sample_idx(sample_idx), .busy(busy),
    .flushing(flushing), .frame_done(frame_done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [2:0] idx; logic st; logic fd; logic er; } exp_t;
  exp_t sbq[$];

  int tests = 0, fails = 0;
  int ce_cnt = 0, stray_err = 0;
  bit flush_seen = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (flushing) flush_seen = 1;
    if (ce) begin
      ce_cnt++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ce: got idx=%0d st=%0b fd=%0b err=%0b, required no ce",
                 sample_idx, straight, frame_done, err);
      end else begin
        e = sbq.pop_front();
        if ({sample_idx, straight, frame_done, err} !== {e.idx, e.st, e.fd, e.er}) begin
          fails++;
          $display("FAIL ce_out: got idx=%0d st=%0b fd=%0b err=%0b, required idx=%0d st=%0b fd=%0b err=%0b",
                   sample_idx, straight, frame_done, err, e.idx, e.st, e.fd, e.er);
        end
      end
    end else begin
      if (err) stray_err++;
      tests++;
      if (frame_done !== 1'b0) begin
        fails++;
        $display("FAIL stray_frame_done: got %b without ce, required 0", frame_done);
      end
    end
  end

  task automatic cyc(input logic v, input logic s, input logic h);
    in_valid = v; in_sof = s; hold = h;
    @(posedge CLK); #1;
    in_valid = 1'b0; in_sof = 1'b0; hold = 1'b0;
  endtask

  task automatic push(input int i, input bit fd, input bit er);
    exp_t e;
    e.idx = i[2:0];
    e.st  = ~e.idx[1];
    e.fd  = fd;
    e.er  = er;
    sbq.push_back(e);
  endtask

  task automatic push_flush();
    if (FL) begin
      push(0, 0, 0);
      push(1, 1, 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      cyc(0, 0, 0);
      n++;
    end
    cyc(0, 0, 0);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected ce still pending, required 0", name, sbq.size());
      sbq.delete();
    end
    tests++;
    if ({busy, flushing} !== 2'b00) begin
      fails++;
      $display("FAIL %s_idle: busy/flushing=%b, required 00", name, {busy, flushing});
    end
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if ({ce, straight, sample_idx, busy, flushing, frame_done, err} !== 9'b0_1_000_0000) begin
      fails++;
      $display("FAIL %s: got ce=%b st=%b idx=%0d busy=%b fl=%b fd=%b err=%b, required 0 1 0 0 0 0 0",
               name, ce, straight, sample_idx, busy, flushing, frame_done, err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1 check_reset_vals("reset_held");
    RST = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check_reset_vals("reset_released");
  endtask

  task automatic test_frame();
    int c0 = ce_cnt;
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 8; k++) begin
      push(k, (k == 7) && !FL, 0);
      cyc(1, 0, 0);
    end
    push_flush();
    wait_drain("frame");
    tests++;
    if (ce_cnt - c0 != (FL ? 10 : 8)) begin
      fails++;
      $display("FAIL frame_ce_count: got %0d, required %0d", ce_cnt - c0, FL ? 10 : 8);
    end
    tests++;
    if (flush_seen !== FL) begin
      fails++;
      $display("FAIL flushing_seen: got %b, required %b", flush_seen, FL);
    end
  endtask

  task automatic test_hold();
    int c0;
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 5; k++) begin push(k, 0, 0); cyc(1, 0, 0); end
    c0 = ce_cnt;
    repeat (3) cyc(1, 0, 1);
    push(5, 0, 0); cyc(1, 0, 0);
    tests++;
    if (ce_cnt - c0 != 1) begin
      fails++;
      $display("FAIL hold_gap: got %0d ce across hold window, required 1", ce_cnt - c0);
    end
    for (int k = 6; k < 8; k++) begin push(k, (k == 7) && !FL, 0); cyc(1, 0, 0); end
    push_flush();
    wait_drain("hold");
  endtask

  task automatic test_resof();
    int e0 = stray_err;
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 5; k++) begin push(k, 0, 0); cyc(1, 0, 0); end
    push(0, 0, 1); cyc(1, 1, 0);
    for (int k = 1; k < 8; k++) begin push(k, (k == 7) && !FL, 0); cyc(1, 0, 0); end
    push_flush();
    wait_drain("resof");
    tests++;
    if (stray_err != e0) begin
      fails++;
      $display("FAIL resof_err_placement: got %0d err without ce, required 0", stray_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 8; k++) begin push(k, (k == 7) && !FL, 0); cyc(1, 0, 0); end
    // second sof lands in the first flush cycle when flush is built in
    push(0, FL, 0); cyc(1, 1, 0);
    for (int k = 1; k < 8; k++) begin push(k, (k == 7) && !FL, 0); cyc(1, 0, 0); end
    push_flush();
    wait_drain("b2b");
  endtask

  task automatic test_idle_err();
    int e0 = stray_err;
    int c0 = ce_cnt;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    tests++;
    if (stray_err - e0 != 1 || ce_cnt != c0) begin
      fails++;
      $display("FAIL idle_err: got err=%0d ce=%0d, required err=1 ce=0", stray_err - e0, ce_cnt - c0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_err_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 4; k++) begin push(k, 0, 0); cyc(1, 0, 0); end
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_reset_vals("rst_async");
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check_reset_vals("rst_held_mid");
    RST = 1'b1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL rst_pending: %0d expected ce pending, required 0", sbq.size());
      sbq.delete();
    end
    push(0, 0, 0); cyc(1, 1, 0);
    for (int k = 1; k < 8; k++) begin push(k, (k == 7) && !FL, 0); cyc(1, 0, 0); end
    push_flush();
    wait_drain("rst_restart");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_resof();
    test_back_to_back();
    test_idle_err();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commutator_ctrl.md
# commutator_ctrl

Sequencer for one stage of cross switches in the streaming FFT pipeline. It counts accepted input samples within a frame and produces the switch clock-enable and `straight` select for that stage. It also produces the per-sample index, busy/flush status, a frame-done strobe and an error strobe. One instance drives all cross switches of a stage, and the data path adds one register of delay so the data lines up with the registered controls.

## Interface
- `LOG_N`, 6: log2 of frame length N; sample index width.
- `SW_LOG`, 2: `straight` changes every 2^SW_LOG samples; flush length is 2^SW_LOG cycles; legal range is 0 ≤ SW_LOG < LOG_N.

- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input sample present this cycle.
- `in_sof`  in  1  start of frame; qualified by `in_valid`.
- `hold`  in  1  global stall; while high nothing is accepted or advanced.
- `ce`  out  1  switch clock enable.
- `straight`  out  1  switch select; 1 means a→x and b→y.
- `sample_idx`  out  LOG_N  index of the sample presented with `ce`.
- `busy`  out  1  state is not IDLE.
- `flushing`  out  1  state is FLUSH.
- `frame_done`  out  1  one-cycle strobe.
- `err`  out  1  one-cycle protocol error strobe.

## Operation
- Accept condition: `in_valid & ~hold`.
- States are IDLE, RUN and FLUSH.
- IDLE:
  - Accepted sample with `in_sof` → RUN; this sample is index 0.
  - Accepted sample without `in_sof` → dropped; `err` pulses; no `ce`.
- RUN:
  - Each accepted sample gets the next index.
  - After index N-1 is accepted → FLUSH, or IDLE when flush is compiled out.
  - Accepted `in_sof` at an index other than 0 → `err` pulses and the frame restarts with that sample as index 0.
- FLUSH:
  - Issues 2^SW_LOG pseudo-samples, one per cycle while `hold` is low, to drain the downstream delay line.
  - Index counter continues from the wrap, so pseudo-samples are indices 0..2^SW_LOG-1.
  - Then → IDLE.
  - Accepted `in_sof` sample during FLUSH aborts the flush: it becomes index 0 of a new frame, `frame_done` pulses for the old frame, and the state goes to RUN.
  - Accepted non-sof sample during FLUSH → `err`, dropped; the flush continues.
- Index counter: LOG_N bits, wraps from N-1 to 0.
- `straight` = ~idx[SW_LOG] for the sample or pseudo-sample issued.
- `hold` high: state, counters and `straight` are frozen; `ce` = 0.
- `frame_done` is asserted together with the last `ce` of a frame: the final flush cycle, the abort cycle, or index N-1 when flush is compiled out.

## Timing
- All outputs are registered.
- Accept at edge t → `ce`=1 with matching `straight` and `sample_idx` in cycle t+1.
- Throughput is one sample per cycle; back-to-back frames need no gap.
- Reset values:
  - `ce`=0, `straight`=1, `sample_idx`=0
  - `busy`=0, `flushing`=0, `frame_done`=0, `err`=0
  - state IDLE, counters 0
- `RST` asserted mid-frame → immediate return to reset values; no `frame_done` for the aborted frame.
- `busy` and `flushing` reflect the state after the edge.

## Configuration
- `COMMUTATOR_FLUSH_EN` defined: the FLUSH state and flush counter are present, as described above.
- `COMMUTATOR_FLUSH_EN` undefined: there is no FLUSH state and `flushing` is tied to 0. After index N-1 the block returns to IDLE and `frame_done` pulses with that sample's `ce`. The delay line then drains only when the next frame's data arrives.

## Test plan
All scenarios use LOG_N=3 and SW_LOG=1 (N=8, flush of 2).
- Reset with stimulus idle → all outputs at reset values; `busy` stays 0.
- `in_sof` followed by 8 contiguous valids (flush enabled):
  - `ce` is high for 10 cycles.
  - `straight` = 1,1,0,0,1,1,0,0,1,1.
  - `sample_idx` = 0..7,0,1.
  - `frame_done` is asserted with the 10th `ce`; `busy` then falls.
- Same frame with `hold` high for 3 cycles after index 4 → a 3-cycle gap in `ce`; index and `straight` sequences are unchanged.
- `in_sof` re-asserted on the sample at index 5 → `err` pulses once; that sample gets `sample_idx`=0; the frame then completes normally.
- New `in_sof` frame starting in the first flush cycle:
  - `frame_done` pulses with that `ce`, and `sample_idx`=0.
  - Eight more samples follow, ending in a normal flush.
- Macro undefined, 8-sample frame → `frame_done` with the 8th `ce`; `flushing` is never 1.
- `RST` asserted at index 3 → outputs return to reset values asynchronously; a new `in_sof` frame then starts at index 0.
